flex_deserializer: RTL and testbench

Parametrised serial-to-parallel converter and next generation of the fixed 16-bit deserializer. Collects one bit per valid cycle into a DATA_W-bit word with selectable bit order. Also flushes partial words, either on an explicit last marker or after a configurable idle timeout, and reports the number of valid bits. It sits between a bit-serial link receiver and word-wide downstream logic.

---
 rtl/deser_pkg.sv | 15 +
 rtl/flex_deserializer_if.sv | 36 +++
 rtl/deser_idle_timer.sv | 27 ++
 rtl/flex_deserializer.sv | 104 ++++++++++
 tb/tb_flex_deserializer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/deser_pkg.sv
// Shared types for the flex_deserializer block: bit order selection and the
// two-state collection FSM encoding.
package deser_pkg;

  typedef enum logic {
    MSB_FIRST,
    LSB_FIRST
  } bit_order_t;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

endpackage

// File: rtl/flex_deserializer_if.sv
// Serial-in / word-out signal bundle. The slave side is the deserializer,
// the master side is the link receiver plus the word consumer.
interface flex_deserializer_if #(
  parameter int DATA_W = 16
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              data_i;
  logic              data_val_i;
  logic              data_last_i;
  logic [DATA_W-1:0] deser_data_o;
  logic              deser_data_val_o;
  logic [CNT_W-1:0]  deser_data_mod_o;
  logic              deser_busy_o;

  modport master (
    output data_i,
    output data_val_i,
    output data_last_i,
    input  deser_data_o,
    input  deser_data_val_o,
    input  deser_data_mod_o,
    input  deser_busy_o
  );

  modport slave (
    input  data_i,
    input  data_val_i,
    input  data_last_i,
    output deser_data_o,
    output deser_data_val_o,
    output deser_data_mod_o,
    output deser_busy_o
  );

endinterface

// File: rtl/deser_idle_timer.sv
// Idle down-counter: reloads on clear, counts while run is high and pulses
// expire on the TIMEOUT-th consecutive run cycle.
module deser_idle_timer #(
  parameter int TIMEOUT = 4
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);
  localparam int             TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  LOAD = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_remain;

  always_ff @(posedge clk_i) begin
    if (srst_i || clear_i) begin
      r_remain <= LOAD;
    end else if (run_i) begin
      r_remain <= (r_remain == '0) ? LOAD : r_remain - TW'(1);
    end
  end

  assign expire_o = run_i && (r_remain == '0);

endmodule

// File: rtl/flex_deserializer.sv
// Serial-to-parallel word assembler with selectable bit order; partial words
// are flushed on a last marker or after an optional idle timeout.
module flex_deserializer
  import deser_pkg::*;
#(
  parameter int         DATA_W    = 16,
  parameter bit_order_t BIT_ORDER = MSB_FIRST,
  parameter int         TIMEOUT   = 0
) (
  input logic                clk_i,
  input logic                srst_i,
  flex_deserializer_if.slave deser_bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  if (DATA_W < 2 || DATA_W > 64) begin : g_bad_width
    $error("flex_deserializer: DATA_W must be within 2..64");
  end

  state_t            r_state;
  logic [DATA_W-1:0] r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_data;
  logic              r_val;
  logic [CNT_W-1:0]  r_mod;
  logic              r_busy;

  int                w_idx;
  logic [DATA_W-1:0] w_sr_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_full;
  logic              w_emit;
  logic              w_expire;
  logic              w_timer_run;
  logic              w_timer_clear;

  assign w_idx = (BIT_ORDER == MSB_FIRST) ? (DATA_W - 1 - int'(r_cnt)) : int'(r_cnt);

  // The shift register is cleared on every emit, so only the slot for the
  // current arrival index needs to be written.
  always_comb begin
    w_sr_next = r_sr;
    for (int k = 0; k < DATA_W; k++) begin
      if (k == w_idx) w_sr_next[k] = deser_bus.data_i;
    end
  end

  assign w_cnt_next    = r_cnt + CNT_W'(1);
  assign w_full        = (w_cnt_next == CNT_W'(DATA_W));
  assign w_timer_run   = (r_state == COLLECT) && !deser_bus.data_val_i;
  assign w_timer_clear = (r_state == IDLE) || deser_bus.data_val_i;
  assign w_emit        = (deser_bus.data_val_i && (w_full || deser_bus.data_last_i)) || w_expire;

  if (TIMEOUT > 0) begin : g_timer
    deser_idle_timer #(
      .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
      .clk_i    (clk_i),
      .srst_i   (srst_i),
      .clear_i  (w_timer_clear),
      .run_i    (w_timer_run),
      .expire_o (w_expire)
    );
  end else begin : g_no_timer
    logic w_timer_unused;
    assign w_timer_unused = w_timer_run ^ w_timer_clear;
    assign w_expire       = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_val   <= 1'b0;
      r_mod   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_val <= 1'b0;
      if (w_emit) begin
        // A timeout emit carries no new bit, so the held word is sent as is.
        r_data  <= deser_bus.data_val_i ? w_sr_next : r_sr;
        r_mod   <= deser_bus.data_val_i ? w_cnt_next : r_cnt;
        r_val   <= 1'b1;
        r_busy  <= 1'b0;
        r_sr    <= '0;
        r_cnt   <= '0;
        r_state <= IDLE;
      end else if (deser_bus.data_val_i) begin
        r_sr    <= w_sr_next;
        r_cnt   <= w_cnt_next;
        r_busy  <= 1'b1;
        r_state <= COLLECT;
      end
    end
  end

  assign deser_bus.deser_data_o     = r_data;
  assign deser_bus.deser_data_val_o = r_val;
  assign deser_bus.deser_data_mod_o = r_mod;
  assign deser_bus.deser_busy_o     = r_busy;

endmodule

// File: tb/tb_flex_deserializer.sv
// Scoreboard bench for flex_deserializer: three configurations share one
// stimulus driver, expected words are queued and checked by a monitor.
module tb_flex_deserializer;
  import deser_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst;
  logic s_data, s_val, s_last;
  int   sel;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [63:0] data;
    int          mod;
    int          cyc;
  } exp_t;
  exp_t q[$];

  flex_deserializer_if #(.DATA_W(16)) if0 ();
  flex_deserializer_if #(.DATA_W(16)) if1 ();
  flex_deserializer_if #(.DATA_W(8))  if2 ();

  assign if0.data_i      = (sel == 0) && s_data;
  assign if0.data_val_i  = (sel == 0) && s_val;
  assign if0.data_last_i = (sel == 0) && s_last;
  assign if1.data_i      = (sel == 1) && s_data;
  assign if1.data_val_i  = (sel == 1) && s_val;
  assign if1.data_last_i = (sel == 1) && s_last;
  assign if2.data_i      = (sel == 2) && s_data;
  assign if2.data_val_i  = (sel == 2) && s_val;
  assign if2.data_last_i = (sel == 2) && s_last;

  flex_deserializer #(.DATA_W(16), .BIT_ORDER(MSB_FIRST), .TIMEOUT(0)) u_dut0 (
    .clk_i(clk), .srst_i(srst), .deser_bus(if0));
  flex_deserializer #(.DATA_W(16), .BIT_ORDER(LSB_FIRST), .TIMEOUT(4)) u_dut1 (
    .clk_i(clk), .srst_i(srst), .deser_bus(if1));
  flex_deserializer #(.DATA_W(8), .BIT_ORDER(MSB_FIRST), .TIMEOUT(2)) u_dut2 (
    .clk_i(clk), .srst_i(srst), .deser_bus(if2));

  logic [63:0] o_data [3];
  logic        o_val  [3];
  int          o_mod  [3];
  logic        o_busy [3];

  assign o_data[0] = 64'(if0.deser_data_o);
  assign o_data[1] = 64'(if1.deser_data_o);
  assign o_data[2] = 64'(if2.deser_data_o);
  assign o_val[0]  = if0.deser_data_val_o;
  assign o_val[1]  = if1.deser_data_val_o;
  assign o_val[2]  = if2.deser_data_val_o;
  assign o_mod[0]  = int'(if0.deser_data_mod_o);
  assign o_mod[1]  = int'(if1.deser_data_mod_o);
  assign o_mod[2]  = int'(if2.deser_data_mod_o);
  assign o_busy[0] = if0.deser_busy_o;
  assign o_busy[1] = if1.deser_busy_o;
  assign o_busy[2] = if2.deser_busy_o;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, dut %0d)", name, act, exp, cyc, sel);
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (o_val[k] === 1'b1) begin
        if (k != sel || q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: dut %0d data=0x%0h mod=%0d at cycle %0d, expected no pulse",
                   k, o_data[k], o_mod[k], cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("word_data", o_data[k], e.data);
          chk("word_mod", 64'(o_mod[k]), 64'(e.mod));
          chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
          chk("busy_at_pulse", 64'(o_busy[k]), 64'd0);
        end
      end
    end
  end

  // Reference model of the selected configuration.
  int          m_w, m_to, m_n, m_idle, n_words;
  bit          m_msb, m_auto;
  logic [63:0] m_acc;

  task automatic select(input int k, input int w, input bit msb, input int to);
    sel = k; m_w = w; m_msb = msb; m_to = to;
    m_acc = '0; m_n = 0; m_idle = 0;
  endtask

  task automatic flush();
    if (m_auto) begin
      q.push_back('{m_acc, m_n, cyc + 1});
      n_words++;
    end
    m_acc = '0; m_n = 0; m_idle = 0;
  endtask

  task automatic cycle(input bit v, input bit b, input bit l);
    @(negedge clk);
    chk("busy", 64'(o_busy[sel]), 64'(m_n > 0));
    s_val = v; s_data = b; s_last = l;
    if (v) begin
      m_acc[m_msb ? (m_w - 1 - m_n) : m_n] = b;
      m_n++;
      m_idle = 0;
      if (m_n == m_w || l) flush();
    end else if (m_n > 0 && m_to > 0) begin
      m_idle++;
      if (m_idle == m_to) flush();
    end
  endtask

  task automatic send_bits(input logic [63:0] bits, input int n, input bit last, input bit lsb);
    for (int k = 0; k < n; k++)
      cycle(1'b1, lsb ? bits[k] : bits[n-1-k], last && (k == n - 1));
  endtask

  task automatic expect_word(input logic [63:0] data, input int mod);
    q.push_back('{data, mod, cyc + 1});
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst = 1'b1; s_val = 1'b0; s_last = 1'b0; s_data = 1'b0;
    m_acc = '0; m_n = 0; m_idle = 0;
    @(negedge clk);
    srst = 1'b0;
  endtask

  logic [63:0] words [3];

  initial begin
    srst = 1'b1; s_val = 1'b0; s_last = 1'b0; s_data = 1'b0;
    m_auto = 1'b0; n_words = 0;
    select(0, 16, 1'b1, 0);
    repeat (3) @(negedge clk);
    srst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("reset_data", o_data[k], 64'd0);
      chk("reset_val", 64'(o_val[k]), 64'd0);
      chk("reset_mod", 64'(o_mod[k]), 64'd0);
      chk("reset_busy", 64'(o_busy[k]), 64'd0);
    end

    // 16-bit MSB first, no timeout
    words[0] = 64'hB7E4; words[1] = 64'h2167; words[2] = 64'hE9D3;
    for (int i = 0; i < 3; i++) begin
      send_bits(words[i], 16, 1'b0, 1'b0);
      expect_word(words[i], 16);
    end
    send_bits(64'b10110, 5, 1'b1, 1'b0);
    expect_word(64'hB000, 5);
    send_bits(64'b1, 1, 1'b1, 1'b0);
    expect_word(64'h8000, 1);
    send_bits(64'h1234, 16, 1'b1, 1'b0);
    expect_word(64'h1234, 16);
    send_bits(64'b110, 3, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    send_bits(64'b1, 1, 1'b1, 1'b0);
    expect_word(64'hD000, 4);
    send_bits(64'h297, 10, 1'b0, 1'b0);
    do_reset();
    send_bits(64'h1234, 16, 1'b0, 1'b0);
    expect_word(64'h1234, 16);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);

    // 16-bit LSB first, TIMEOUT=4
    select(1, 16, 1'b0, 4);
    send_bits(64'hB7E4, 16, 1'b0, 1'b1);
    expect_word(64'hB7E4, 16);
    send_bits(64'hB7E4, 16, 1'b0, 1'b0);
    expect_word(64'h27ED, 16);
    send_bits(64'b111, 3, 1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    expect_word(64'h0007, 3);
    send_bits(64'b111, 3, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    expect_word(64'h000F, 4);
    repeat (6) cycle(1'b0, 1'b0, 1'b0);

    // 8-bit MSB first, TIMEOUT=2, random gaps and last markers
    select(2, 8, 1'b1, 2);
    m_auto = 1'b1;
    for (int guard = 0; guard < 40000 && n_words < 1000; guard++) begin
      bit v, b, l;
      v = ($urandom_range(0, 4) != 0);
      b = 1'($urandom_range(0, 1));
      l = v && ($urandom_range(0, 7) == 0);
      cycle(v, b, l);
      if ($urandom_range(0, 19) == 0) repeat (3) cycle(1'b0, 1'b0, 1'b0);
    end
    chk("random_word_count", 64'(n_words >= 1000), 64'd1);
    repeat (6) cycle(1'b0, 1'b0, 1'b0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
